sevenseg_scan_driver: RTL and testbench
=======================================

# sevenseg_scan_driver

- Time-multiplexed four-digit seven-segment driver.
- Consumes two BCD digit pairs (tens/ones) from the binary-to-BCD converters, minutes pair and seconds pair, and scans them onto the board's common-anode display.
- Provides a registered display latch, a refresh prescaler, a digit scan counter, leading-zero blanking, blinking, and invalid-BCD indication.
- Sits directly downstream of the binary-to-BCD stage and drives the FPGA display pins.

## Interface
- REFRESH_DIV, 100000, clock cycles each digit is driven (≥2)
- BLINK_DIV, 50000000, clock cycles per blink half-period (≥2)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- load  input  1  capture min_tens/min_ones/sec_tens/sec_ones into display latch
- min_tens  input  4  BCD, leftmost digit (digit 3)
- min_ones  input  4  BCD, digit 2
- sec_tens  input  4  BCD, digit 1
- sec_ones  input  4  BCD, rightmost digit (digit 0)
- blank_lz  input  1  blank digit 3 when its latched value is 0
- blink_en  input  1  enable whole-display blinking
- an  output  4  anode enables, active-low, an[i] = digit i
- seg  output  7  cathodes, active-low, seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active-low

## Operation
- Display latch (16 bits): loads all four inputs on an edge with load=1, otherwise holds. Reset value is all zero.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, the scan index idx advances 0→1→2→3→0.
  - Reset sets both the counter and idx to 0.
- Decode of the selected latched digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bit order g..a)
  - Values 10–15 show a dash: seg=0111111.
- dp: 0 (lit) only while idx=2; otherwise 1.
- Blanking: a digit is blanked when either condition below holds.
  - blank_lz=1, idx=3, and latched min_tens=0.
  - blink_en=1 and blink_phase=1.
- Blanked digit output: an=1111, seg=1111111, dp=1. The scan timing continues unchanged.
- Blink counter:
  - Runs 0..BLINK_DIV-1 only while blink_en=1.
  - blink_phase toggles at each terminal count.
  - While blink_en=0, the counter and phase are held at 0.
  - Deasserting blink_en mid-phase un-blanks on the next edge.
- Otherwise an = ~(1<<idx) and seg = decode(digit[idx]).
- Only digits 0–3 exist; idx never takes another value.

## Timing
- an, seg and dp are registered. Reset values: an=1111, seg=1111111, dp=1.
- First edge after rst_n rises: an=1110, seg=decode(latched sec_ones)=1000000 (latch is 0).
- Outputs reflect idx, latch, blank_lz and blink state with 1-cycle latency.
- Each digit is driven for exactly REFRESH_DIV consecutive cycles; a full scan takes 4·REFRESH_DIV cycles.
- load at edge k: new values appear on the outputs at edge k+1 (for whichever digit is active). No change to scan timing.
- load asserted on the same edge idx advances: the new digit shows the new latched value one edge later. No mixed frame within a digit slot beyond that single cycle.
- blink_phase toggles every BLINK_DIV cycles while blink_en=1. The blank/unblank takes effect on the edge after the toggle.
- Reset asserted mid-scan: all outputs, counters, idx and latch go to reset values immediately, independent of clk.
- Inputs are sampled only on load=1. Input changes with load=0 have no effect.

## Test plan
- Reset then release, REFRESH_DIV=4:
  - Outputs are 1111/1111111/1 during reset.
  - From the first edge: an cycles 1110,1101,1011,0111 every 4 cycles, seg=1000000 throughout.
  - dp=0 only during the 1011 slot.
- load with min_tens=1, min_ones=2, sec_tens=5, sec_ones=9:
  - The scan shows seg 0010000 (9), 0010010 (5), 0100100 (2) with dp=0, then 1111001 (1).
  - Changing inputs without load leaves the display unchanged.
- load 0,7,3,0 with blank_lz=1: the digit-3 slot shows an=1111, seg=1111111; the other slots show 0,3,7. With blank_lz=0, digit 3 shows 1000000.
- load sec_ones=12 (invalid BCD): the digit-0 slot shows seg=0111111.
- blink_en=1, BLINK_DIV=16:
  - Display is fully dark for 16 cycles, then normal for 16 cycles, repeating.
  - The scan index keeps advancing throughout.
  - Dropping blink_en during a dark phase restores the display on the next edge.
- Assert rst_n=0 asynchronously mid-slot: outputs are 1111/1111111/1 before the next clk edge. After release, the scan restarts at digit 0 with a zero latch.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexed four-digit common-anode seven-segment driver. Latches a
// minutes/seconds BCD frame, scans the digits with a refresh prescaler, and
// supports leading-zero blanking, whole-display blinking and a dash for
// non-BCD digit values. All display pins are registered and active-low.
module sevenseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Scan index values; digit 0 is the rightmost (seconds ones).
    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [3:0] AN_DARK  = 4'b1111;

    // Segment pattern for one digit, bit order g..a, active-low.
    // Anything outside 0..9 renders as a dash so bad upstream data is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [15:0]   r_latch;
    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_ref_tc;
    logic          w_blink_tc;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    assign w_ref_tc   = (r_ref_cnt == REF_LAST);
    assign w_blink_tc = (r_blink_cnt == BLINK_LAST);

    // Display latch: capture the whole frame on load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch <= 16'h0000;
        end else if (load) begin
            r_latch <= {min_tens, min_ones, sec_tens, sec_ones};
        end else begin
            r_latch <= r_latch;
        end
    end

    // Refresh prescaler and scan index; idx steps on the prescaler wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt <= '0;
            r_idx     <= DIG_SEC_ONES;
        end else if (w_ref_tc) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + RW'(1);
            r_idx     <= r_idx;
        end
    end

    // Blink timebase: free-runs only while blinking, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!blink_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_tc) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BW'(1);
            r_blink_phase <= r_blink_phase;
        end
    end

    // Select the latched digit and anode pattern for the current scan slot.
    always_comb begin
        w_digit  = r_latch[3:0];
        w_an_nxt = 4'b1110;
        case (r_idx)
            DIG_SEC_ONES: begin w_digit = r_latch[3:0];   w_an_nxt = 4'b1110; end
            DIG_SEC_TENS: begin w_digit = r_latch[7:4];   w_an_nxt = 4'b1101; end
            DIG_MIN_ONES: begin w_digit = r_latch[11:8];  w_an_nxt = 4'b1011; end
            DIG_MIN_TENS: begin w_digit = r_latch[15:12]; w_an_nxt = 4'b0111; end
            default:      begin w_digit = r_latch[3:0];   w_an_nxt = AN_DARK; end
        endcase
    end

    // Blanking decision and the next value of the segment/dp pins.
    always_comb begin
        w_blank = ((blank_lz == 1'b1) && (r_idx == DIG_MIN_TENS) && (r_latch[15:12] == 4'd0))
               || ((blink_en == 1'b1) && (r_blink_phase == 1'b1));
        if (w_blank) begin
            w_seg_nxt = SEG_DARK;
            w_dp_nxt  = 1'b1;
        end else begin
            w_seg_nxt = bcd_to_seg(w_digit);
            w_dp_nxt  = (r_idx == DIG_MIN_ONES) ? 1'b0 : 1'b1;
        end
    end

    // Output pin registers; a blanked slot keeps every anode off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_DARK;
            r_seg <= SEG_DARK;
            r_dp  <= 1'b1;
        end else if (w_blank) begin
            r_an  <= AN_DARK;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver with small dividers.
// Expected pin values are derived from the edge count since reset, the frame
// the bench has loaded and the blink start edge, queued before each edge and
// compared one time step after it.
module tb_sevenseg_scan_driver;

    localparam int RD = 4;
    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] min_tens = 4'd0;
    logic [3:0] min_ones = 4'd0;
    logic [3:0] sec_tens = 4'd0;
    logic [3:0] sec_ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic       blink_en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    logic [15:0] m_latch = 16'h0000;
    int          blink_start = 0;

    sevenseg_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones),
        .blank_lz(blank_lz), .blink_en(blink_en),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected pins after edge number n (first edge after reset release is 1).
    function automatic exp_t model_out();
        exp_t e;
        int   slot;
        logic dark;
        logic lz;
        slot = ((n - 1) / RD) % 4;
        dark = blink_en && (n >= blink_start) && ((((n - blink_start) / BD) % 2) == 1);
        lz   = blank_lz && (slot == 3) && (m_latch[15:12] == 4'd0);
        if (dark || lz) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
            e.dp  = 1'b1;
        end else begin
            e.an  = ~(4'b0001 << slot);
            e.seg = ref_seg(m_latch[slot*4 +: 4]);
            e.dp  = (slot == 2) ? 1'b0 : 1'b1;
        end
        return e;
    endfunction

    task automatic tick(input string name);
        exp_t e;
        n = n + 1;
        q.push_back(model_out());
        @(posedge clk);
        if (load) m_latch = {min_tens, min_ones, sec_tens, sec_ones};
        #1;
        e = q.pop_front();
        checks = checks + 1;
        if (an !== e.an) begin
            errors = errors + 1;
            $display("FAIL %s an edge %0d: got %b expected %b", name, n, an, e.an);
        end
        checks = checks + 1;
        if (seg !== e.seg) begin
            errors = errors + 1;
            $display("FAIL %s seg edge %0d: got %b expected %b", name, n, seg, e.seg);
        end
        checks = checks + 1;
        if (dp !== e.dp) begin
            errors = errors + 1;
            $display("FAIL %s dp edge %0d: got %b expected %b", name, n, dp, e.dp);
        end
    endtask

    task automatic run(input int count, input string name);
        for (int i = 0; i < count; i++) tick(name);
    endtask

    task automatic check_dark(input string name);
        exp_t e;
        q.push_back('{an: 4'b1111, seg: 7'b1111111, dp: 1'b1});
        e = q.pop_front();
        checks = checks + 1;
        if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
            errors = errors + 1;
            $display("FAIL %s: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, e.an, e.seg, e.dp);
        end
    endtask

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mo,
                           input logic [3:0] st, input logic [3:0] so, input string name);
        min_tens = mt; min_ones = mo; sec_tens = st; sec_ones = so;
        load = 1'b1;
        tick(name);
        load = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        check_dark("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        m_latch = 16'h0000;
        run(2 * 4 * RD, "scan_zero");
    endtask

    task automatic test_load();
        do_load(4'd1, 4'd2, 4'd5, 4'd9, "load_1259");
        run(4 * RD, "show_1259");
        min_tens = 4'd8; min_ones = 4'd8; sec_tens = 4'd8; sec_ones = 4'd8;
        run(4 * RD, "no_load_hold");
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        do_load(4'd0, 4'd7, 4'd3, 4'd0, "load_0730");
        run(4 * RD, "lz_on");
        blank_lz = 1'b0;
        run(4 * RD, "lz_off");
    endtask

    task automatic test_invalid();
        do_load(4'd4, 4'd6, 4'd15, 4'd12, "load_bad");
        run(4 * RD, "invalid_dash");
    endtask

    task automatic test_back_to_back();
        // Loads landing on several phases of the slot, including the idx step.
        for (int k = 0; k < 6; k++) begin
            do_load(4'(k), 4'(k + 1), 4'(k + 2), 4'(k + 3), "b2b_load");
            run(k % 3, "b2b_gap");
        end
        run(4 * RD, "b2b_tail");
    endtask

    task automatic test_blink();
        do_load(4'd2, 4'd3, 4'd4, 4'd5, "load_blink");
        blink_start = n + 1;
        blink_en = 1'b1;
        run(3 * BD + 4, "blink_run");
        blink_en = 1'b0;
        run(2 * RD, "blink_drop");
    endtask

    task automatic test_async_reset();
        run(RD + 1, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_reset");
        m_latch = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        run(4 * RD, "after_async");
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank_lz();
        test_invalid();
        test_back_to_back();
        test_blink();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
